// File: rtl/series_sequencer.sv
// series_sequencer: Moore FSM sequencing the shared-multiplier
// odd-power series datapath (x2, pwr, term, acc, coefficient ROM).
module series_sequencer #(
  parameter int NTERMS  = 16,
  parameter int CW      = 4,
  parameter int MUL_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          mul_a_sel,
  output logic [1:0]    mul_b_sel,
  output logic          x2_ld,
  output logic          pwr_init,
  output logic          pwr_ld,
  output logic          term_ld,
  output logic          acc_clr,
  output logic          acc_ld,
  output logic [CW-1:0] rom_addr,
  output logic          busy,
  output logic          ready
);

  localparam int WW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] KLAST = CW'(NTERMS - 1);
  localparam logic [WW-1:0] WLAST = WW'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SQ,
    TERM,
    ACC,
    POW
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] k;
  logic [CW-1:0] k_n;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] wcnt_n;
  logic          ready_n;
  logic          last;
  logic          klast;
  logic          mul_state;

  assign last      = (wcnt == WLAST);
  assign klast     = (k == KLAST);
  assign mul_state = (state == SQ) || (state == TERM) || (state == POW);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      wcnt  <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_n;
      k     <= k_n;
      wcnt  <= wcnt_n;
      ready <= ready_n;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    ready_n = ready;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SETUP;
          ready_n = 1'b0;
        end
      end
      SETUP: begin
        state_n = SQ;
        k_n     = '0;
      end
      SQ: begin
        if (last) state_n = TERM;
      end
      TERM: begin
        if (last) state_n = ACC;
      end
      ACC: begin
        if (klast) begin
          state_n = IDLE;
          ready_n = 1'b1;
        end else begin
          state_n = POW;
        end
      end
      POW: begin
        if (last) begin
          state_n = TERM;
          k_n     = k + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // counter only runs while a multiply is being waited out
    if (state_n != state || !mul_state) wcnt_n = '0;
    else                                wcnt_n = wcnt + 1'b1;
  end

  always_comb begin
    mul_a_sel = 1'b0;
    mul_b_sel = 2'd0;
    x2_ld     = 1'b0;
    pwr_init  = 1'b0;
    pwr_ld    = 1'b0;
    term_ld   = 1'b0;
    acc_clr   = 1'b0;
    acc_ld    = 1'b0;
    rom_addr  = k;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: ;
      SETUP: begin
        acc_clr  = 1'b1;
        pwr_init = 1'b1;
      end
      SQ: begin
        x2_ld = last;
      end
      TERM: begin
        mul_a_sel = 1'b1;
        mul_b_sel = 2'd1;
        term_ld   = last;
      end
      ACC: begin
        acc_ld = 1'b1;
      end
      POW: begin
        mul_a_sel = 1'b1;
        mul_b_sel = 2'd2;
        pwr_ld    = last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_series_sequencer.sv
// tb_series_sequencer: randomized scoreboard bench, two DUT
// configurations (16 terms / latency 1 and 4 terms / latency 3).
module tb_series_sequencer;

  typedef struct packed {
    logic       chk_sel;
    logic       a;
    logic [1:0] b;
    logic [5:0] stb;
    logic [3:0] rom;
  } rec_t;

  // strobe vector order: x2_ld pwr_init pwr_ld term_ld acc_clr acc_ld
  localparam logic [5:0] S_X2   = 6'b100000;
  localparam logic [5:0] S_INIT = 6'b010010;
  localparam logic [5:0] S_PWR  = 6'b001000;
  localparam logic [5:0] S_TERM = 6'b000100;
  localparam logic [5:0] S_ACC  = 6'b000001;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  function automatic real coef(input int kk);
    real f;
    f = 1.0;
    for (int i = 1; i <= 2 * kk + 1; i++) f = f * i;
    return ((kk % 2) != 0) ? -1.0 / f : 1.0 / f;
  endfunction

  function automatic real series(input real xv, input int n);
    real s;
    real p;
    s = 0.0;
    p = xv;
    for (int kk = 0; kk < n; kk++) begin
      s = s + coef(kk) * p;
      p = p * xv * xv;
    end
    return s;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int N    = (g == 0) ? 16 : 4;
    localparam int L    = (g == 0) ? 1 : 3;
    localparam int LEN  = 1 + L + N * (L + 1) + (N - 1) * L;
    localparam int TIDX = 1 + L + 3 * (2 * L + 1);

    logic       reset;
    logic       start;
    logic       a;
    logic [1:0] b;
    logic       x2_ld;
    logic       pwr_init;
    logic       pwr_ld;
    logic       term_ld;
    logic       acc_clr;
    logic       acc_ld;
    logic [3:0] rom;
    logic       busy;
    logic       ready;

    series_sequencer #(
      .NTERMS (N),
      .CW     (4),
      .MUL_LAT(L)
    ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .mul_a_sel(a),
      .mul_b_sel(b),
      .x2_ld    (x2_ld),
      .pwr_init (pwr_init),
      .pwr_ld   (pwr_ld),
      .term_ld  (term_ld),
      .acc_clr  (acc_clr),
      .acc_ld   (acc_ld),
      .rom_addr (rom),
      .busy     (busy),
      .ready    (ready)
    );

    rec_t       q[$];
    int         rem = 0;
    logic       rdy_m = 1'b0;
    logic [3:0] kidle = 4'd0;
    logic       fin = 1'b0;
    logic       done = 1'b0;

    task automatic push_cyc(input logic cs, input logic av,
                            input logic [1:0] bv, input logic [5:0] sv,
                            input int rv);
      rec_t r;
      r.chk_sel = cs;
      r.a       = av;
      r.b       = bv;
      r.stb     = sv;
      r.rom     = 4'(rv);
      q.push_back(r);
    endtask

    // expected per-cycle trace of one whole run
    task automatic push_run();
      push_cyc(1'b0, 1'b0, 2'd0, S_INIT, int'(kidle));
      for (int i = 0; i < L; i++)
        push_cyc(1'b1, 1'b0, 2'd0, (i == L - 1) ? S_X2 : 6'd0, 0);
      for (int kk = 0; kk < N; kk++) begin
        for (int i = 0; i < L; i++)
          push_cyc(1'b1, 1'b1, 2'd1, (i == L - 1) ? S_TERM : 6'd0, kk);
        push_cyc(1'b0, 1'b0, 2'd0, S_ACC, kk);
        if (kk < N - 1)
          for (int i = 0; i < L; i++)
            push_cyc(1'b1, 1'b1, 2'd2, (i == L - 1) ? S_PWR : 6'd0, kk);
      end
    endtask

    always @(posedge clock or posedge reset) begin : model
      if (reset) begin
        q.delete();
        rem   = 0;
        rdy_m = 1'b0;
        kidle = 4'd0;
      end else if (rem == 0 && start === 1'b1) begin
        push_run();
        rem   = LEN;
        rdy_m = 1'b0;
      end else if (rem > 0) begin
        rem = rem - 1;
        if (rem == 0) begin
          rdy_m = 1'b1;
          kidle = 4'(N - 1);
        end
      end
    end

    int   bcnt = 0;
    logic rdy_prev = 1'b0;
    real  xr = 0.5;
    real  x2r = 0.0;
    real  pwrr = 0.0;
    real  termr = 0.0;
    real  accr = 0.0;
    real  mulr;
    real  opb;
    real  expv;

    always @(negedge clock) begin : mon
      rec_t       e;
      logic [5:0] s;
      s = {x2_ld, pwr_init, pwr_ld, term_ld, acc_clr, acc_ld};
      checks++;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (busy !== 1'b1 || ready !== 1'b0 || s !== e.stb ||
            rom !== e.rom ||
            (e.chk_sel && (a !== e.a || b !== e.b))) begin
          errors++;
          $display("FAIL trace inst%0d t=%0t busy=%b ready=%b stb=%b sel=%b/%0d rom=%0d, required busy=1 ready=0 stb=%b sel=%b/%0d rom=%0d",
                   g, $time, busy, ready, s, a, b, rom,
                   e.stb, e.a, e.b, e.rom);
        end
      end else begin
        if (busy !== 1'b0 || ready !== rdy_m || s !== 6'd0 ||
            rom !== kidle) begin
          errors++;
          $display("FAIL idle inst%0d t=%0t busy=%b ready=%b stb=%b rom=%0d, required busy=0 ready=%b stb=000000 rom=%0d",
                   g, $time, busy, ready, s, rom, rdy_m, kidle);
        end
      end
      if (busy === 1'b1) begin
        bcnt++;
      end else if (bcnt > 0) begin
        if (reset !== 1'b1) begin
          checks++;
          if (bcnt != LEN) begin
            errors++;
            $display("FAIL busy_len inst%0d got %0d cycles, required %0d",
                     g, bcnt, LEN);
          end
        end
        bcnt = 0;
      end
      if (ready === 1'b1 && rdy_prev !== 1'b1) begin
        expv = series(xr, N);
        checks++;
        if (accr - expv > 1e-12 || expv - accr > 1e-12) begin
          errors++;
          $display("FAIL acc_value inst%0d got %0.15f, required %0.15f",
                   g, accr, expv);
        end
      end
      if (fin && !done) begin
        checks++;
        if (q.size() != 0) begin
          errors++;
          $display("FAIL drain inst%0d %0d cycles left, required 0",
                   g, q.size());
        end
        done = 1'b1;
      end
      // behavioural datapath driven by the strobes of this cycle
      opb  = (b == 2'd0) ? xr : (b == 2'd1) ? coef(int'(rom)) :
             (b == 2'd2) ? x2r : 0.0;
      mulr = (a ? pwrr : xr) * opb;
      if (acc_ld === 1'b1)   accr  = accr + termr;
      if (acc_clr === 1'b1)  accr  = 0.0;
      if (x2_ld === 1'b1)    x2r   = mulr;
      if (pwr_init === 1'b1) pwrr  = xr;
      if (pwr_ld === 1'b1)   pwrr  = mulr;
      if (term_ld === 1'b1)  termr = mulr;
      rdy_prev = ready;
    end

    initial begin : stim
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (10) @(posedge clock);
      // single pulse run
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (LEN + 3) @(posedge clock);
      // starts at cycles 5 and 20 of a busy run are ignored
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (5) @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (14) @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (LEN + 3) @(posedge clock);
      // reset in the first cycle of the 4th TERM
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (TIDX) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (LEN + 3) @(posedge clock);
      // start held across several runs
      #1 start = 1'b1;
      repeat (2 * LEN + 5) @(posedge clock);
      #1 start = 1'b0;
      repeat (LEN + 3) @(posedge clock);
      // random pulses and gaps
      for (int i = 0; i < 12; i++) begin
        #1 start = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1 start = 1'b0;
        repeat ($urandom_range(0, LEN + 4)) @(posedge clock);
      end
      repeat (LEN + 5) @(posedge clock);
      fin = 1'b1;
    end
  end

  initial begin : main
    int t;
    t = 0;
    while (!(inst[0].done && inst[1].done) && t < 20000) begin
      @(posedge clock);
      t++;
    end
    if (t >= 20000) begin
      $display("FAIL timeout after %0d cycles, required completion", t);
      $fatal(1, "bench did not complete");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
